// File: rtl/mdr_in_word_splitter.sv
// Splits a 16-bit word into two byte writes (or issues one byte write) to a
// byte-wide memory, stalling on mem_ack and pulsing done when finished.
module mdr_in_word_splitter #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_mode,
    input  logic [15:0] word_in,
    input  logic [15:0] addr_in,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] latchWord_q, latchWord_d;
    logic [15:0] latchAddr_q, latchAddr_d;
    logic        byteMode_q, byteMode_d;
    logic [15:0] heldAddr_q;
    logic [7:0]  heldData_q;
    logic [15:0] addrPlusOne;

    assign addrPlusOne = latchAddr_q + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            latchWord_q <= 16'h0000;
            latchAddr_q <= 16'h0000;
            byteMode_q  <= 1'b0;
            heldAddr_q  <= 16'h0000;
            heldData_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            latchWord_q <= latchWord_d;
            latchAddr_q <= latchAddr_d;
            byteMode_q  <= byteMode_d;
            heldAddr_q  <= mem_addr;
            heldData_q  <= mem_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        latchWord_d = latchWord_q;
        latchAddr_d = latchAddr_q;
        byteMode_d  = byteMode_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    latchWord_d = word_in;
                    latchAddr_d = addr_in;
                    byteMode_d  = byte_mode;
                    state_d     = byte_mode ? SECOND : FIRST;
                end
            end
            FIRST: begin
                if (mem_ack) begin
                    state_d = SECOND;
                end
            end
            SECOND: begin
                if (mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address/data are live only while writing; otherwise they replay the
    // value of the previous cycle so the bus holds its last write.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = heldAddr_q;
        mem_data = heldData_q;
        case (state_q)
            FIRST: begin
                mem_we   = 1'b1;
                mem_addr = latchAddr_q;
                mem_data = HIGH_FIRST ? latchWord_q[15:8] : latchWord_q[7:0];
            end
            SECOND: begin
                mem_we = 1'b1;
                if (byteMode_q) begin
                    mem_addr = latchAddr_q;
                    mem_data = latchWord_q[7:0];
                end else begin
                    mem_addr = addrPlusOne;
                    mem_data = HIGH_FIRST ? latchWord_q[7:0] : latchWord_q[15:8];
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: doc/mdr_in_word_splitter.md
MDR_IN_WORD_SPLITTER -- requirements
Module: mdr_in_word_splitter

Interface
REQ-001 The block SHALL have parameter HIGH_FIRST, default 1, meaning: 1 writes the high byte to base address and the low byte to base+1; 0 swaps the two.
REQ-002 Port clk  input  1  clock; all state SHALL change on its rising edge only.
REQ-003 Port rst  input  1  reset; asynchronous, active-low.
REQ-004 Port start  input  1  request to write one word or byte; sampled only in IDLE.
REQ-005 Port byte_mode  input  1  1 selects a single-byte write of word_in[7:0]; sampled with start.
REQ-006 Port word_in  input  16  data word to split; sampled with start.
REQ-007 Port addr_in  input  16  base byte address; sampled with start.
REQ-008 Port mem_ack  input  1  memory accepted the current byte write this cycle.
REQ-009 Port mem_we  output  1  byte write strobe to memory.
REQ-010 Port mem_addr  output  16  byte address for the current write.
REQ-011 Port mem_data  output  8  byte data for the current write.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port done  output  1  one-cycle pulse on transfer completion.

Function
REQ-014 The FSM SHALL have states IDLE, FIRST, SECOND and DONE, held in a registered state variable.
REQ-015 In IDLE with start=1, the block SHALL latch word_in, addr_in and byte_mode.
REQ-016 On that same edge, it SHALL go to FIRST when byte_mode=0 and to SECOND when byte_mode=1.
REQ-017 In IDLE with start=0, the state SHALL not change; start SHALL be ignored in every state other than IDLE.
REQ-018 In FIRST, the block SHALL drive mem_we=1 and mem_addr=latched addr.
REQ-019 In FIRST, mem_data SHALL be the latched high byte when HIGH_FIRST=1 and the latched low byte when HIGH_FIRST=0.
REQ-020 In SECOND, for a word transfer, the block SHALL drive mem_we=1, mem_addr=latched addr+1 and mem_data=the other byte.
REQ-021 In SECOND, for a byte transfer, the block SHALL drive mem_we=1, mem_addr=latched addr and mem_data=latched low byte, regardless of HIGH_FIRST.
REQ-022 The addr+1 sum SHALL be 16-bit modulo, so 0xFFFF+1 gives 0x0000 with no carry out.
REQ-023 FIRST SHALL hold, with all outputs stable, until mem_ack=1, then go to SECOND.
REQ-024 SECOND SHALL hold, with all outputs stable, until mem_ack=1, then go to DONE.
REQ-025 mem_ack SHALL be ignored in IDLE and DONE.
REQ-026 In DONE, the block SHALL drive done=1 and mem_we=0, and go to IDLE on the next edge.
REQ-027 A new start SHALL be accepted no earlier than the cycle after DONE.
REQ-028 With mem_ack tied high, latency from start to done SHALL be 3 cycles for a word (FIRST, SECOND, DONE) and 2 cycles for a byte.
REQ-029 In IDLE and DONE, mem_addr and mem_data SHALL hold their last values; only mem_we qualifies them.
REQ-030 Latched word, address and mode SHALL not change while busy=1, even if word_in, addr_in or byte_mode change.

Reset
REQ-031 When rst=0, asynchronously: state SHALL be IDLE, latched word=0x0000, latched addr=0x0000, byte_mode latch=0.
REQ-032 During reset, outputs SHALL be mem_we=0, busy=0, done=0, mem_addr=0x0000, mem_data=0x00.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer immediately with no further mem_we and no done pulse.
REQ-034 After rst returns to 1, the first rising edge SHALL sample start normally.

Verification
REQ-035 Word write, HIGH_FIRST=1, ack tied high: start, word 0xA55A, addr 0x1000 -> cycle1 we, 0x1000, 0xA5; cycle2 we, 0x1001, 0x5A; cycle3 done=1; cycle4 busy=0.
REQ-036 Byte write: start, byte_mode=1, word 0x12EF, addr 0x2003 -> one write at 0x2003 of 0xEF; done on the following cycle; no write to 0x2004.
REQ-037 Stalled ack: word 0xBEEF at 0x0040, mem_ack low 3 cycles in FIRST -> we, 0x0040, 0xBE held 4 cycles; word_in changes meanwhile have no effect; second byte 0xEF at 0x0041.
REQ-038 Address wrap: word 0x0102 at 0xFFFF -> 0x01 at 0xFFFF, then 0x02 at 0x0000; with HIGH_FIRST=0, 0x02 at 0xFFFF, then 0x01 at 0x0000.
REQ-039 Reset mid-transfer: rst low during SECOND -> mem_we=0 and busy=0 asynchronously; no done pulse; a start issued after release behaves as in REQ-035.
REQ-040 Start while busy: a second start pulse in FIRST, SECOND or DONE -> ignored; exactly one done per accepted start; back-to-back start in the cycle after DONE is accepted.
